// File: rtl/link_up_pkg.sv
// Shared types and width helpers for the upstream link serializer slice.
package link_up_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int beat_w(input int num_ch, input int ch_width);
    return num_ch * ch_width;
  endfunction

  function automatic int core_w(input int num_ch, input int ch_width, input int ratio);
    return num_ch * ch_width * ratio;
  endfunction

  function automatic int cred_w(input int credits);
    return $clog2(credits + 1);
  endfunction

  // A single-beat word still needs a one-bit beat counter.
  function automatic int bcnt_w(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/link_credit_counter.sv
// Token-batched credit counter: one credit per consume, TOKEN_BATCH per token,
// saturating at CREDITS with a sticky overflow flag.
module link_credit_counter
  import link_up_pkg::*;
#(
  parameter int CREDITS     = 16,
  parameter int TOKEN_BATCH = 4,
  localparam int CRED_W     = cred_w(CREDITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              consume_i,
  input  logic              token_i,
  output logic [CRED_W-1:0] count_o,
  output logic              overflow_o
);

  // One extra bit holds CREDITS + TOKEN_BATCH before saturation.
  localparam int SUM_W = CRED_W + 1;

  logic [CRED_W-1:0] count_q, count_d;
  logic              err_q, err_d;
  logic [SUM_W-1:0]  sum;

  always_comb begin
    sum     = SUM_W'(count_q) + (token_i ? SUM_W'(TOKEN_BATCH) : '0) - SUM_W'(consume_i);
    count_d = sum[CRED_W-1:0];
    err_d   = err_q;
    if (sum > SUM_W'(CREDITS)) begin
      count_d = CRED_W'(CREDITS);
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= CRED_W'(CREDITS);
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = err_q;

endmodule

// File: rtl/link_upstream_serializer.sv
// N-channel upstream serializer: one core word goes out as RATIO beats,
// LSB slice first, gated by a token-batched credit counter.
module link_upstream_serializer
  import link_up_pkg::*;
#(
  parameter int CH_WIDTH    = 8,
  parameter int NUM_CH      = 2,
  parameter int RATIO       = 4,
  parameter int CREDITS     = 16,
  parameter int TOKEN_BATCH = 4,
  parameter int CNT_W       = 7,
  localparam int BEAT_W     = beat_w(NUM_CH, CH_WIDTH),
  localparam int CORE_W     = core_w(NUM_CH, CH_WIDTH, RATIO),
  localparam int CRED_W     = cred_w(CREDITS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_valid_i,
  input  logic [CORE_W-1:0] core_data_i,
  output logic              core_ready_o,
  input  logic              io_token_i,
  output logic [NUM_CH-1:0] io_valid_o,
  output logic [BEAT_W-1:0] io_data_o,
  output logic [CRED_W-1:0] credit_cnt_o,
  output logic [CNT_W-1:0]  sent_cnt_o,
  output logic              busy_o,
  output logic              err_token_overflow_o
);

  localparam int BCNT_W = bcnt_w(RATIO);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(RATIO - 1);

  state_e            state_q, state_d;
  logic [BCNT_W-1:0] beat_q, beat_d;
  logic [CORE_W-1:0] shift_q, shift_d;
  logic [BEAT_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              accept;
  logic              last_beat;

  assign core_ready_o = ((state_q == IDLE) || (beat_q == LAST_BEAT)) && (credit_cnt_o != '0);
  assign accept       = core_valid_i && core_ready_o;
  assign last_beat    = (state_q == SEND) && (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    data_d  = data_q;
    sent_d  = sent_q;
    // Accept on the final beat chains straight into the next word's beat 0.
    if (accept) begin
      state_d = SEND;
      beat_d  = '0;
      data_d  = core_data_i[BEAT_W-1:0];
      shift_d = core_data_i >> BEAT_W;
    end else if (state_q == SEND) begin
      if (beat_q == LAST_BEAT) begin
        state_d = IDLE;
      end else begin
        beat_d  = beat_q + BCNT_W'(1);
        data_d  = shift_q[BEAT_W-1:0];
        shift_d = shift_q >> BEAT_W;
      end
    end
    if (last_beat) begin
      sent_d = sent_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      sent_q  <= sent_d;
    end
  end

  link_credit_counter #(
    .CREDITS     (CREDITS),
    .TOKEN_BATCH (TOKEN_BATCH)
  ) u_credit (
    .clk        (clk),
    .rst        (rst),
    .consume_i  (accept),
    .token_i    (io_token_i),
    .count_o    (credit_cnt_o),
    .overflow_o (err_token_overflow_o)
  );

  assign io_valid_o = {NUM_CH{state_q == SEND}};
  assign io_data_o  = data_q;
  assign sent_cnt_o = sent_q;
  assign busy_o     = (state_q == SEND);

endmodule

// File: tb/tb_link_upstream_serializer.sv
// Directed bench for the upstream serializer: default build plus a RATIO=1 build.
module tb_link_upstream_serializer;

  logic        clk = 1'b0;
  logic        rst;
  // default build (8x2 channels, RATIO=4)
  logic        core_valid_i;
  logic [63:0] core_data_i;
  logic        core_ready_o;
  logic        io_token_i;
  logic [1:0]  io_valid_o;
  logic [15:0] io_data_o;
  logic [4:0]  credit_cnt_o;
  logic [6:0]  sent_cnt_o;
  logic        busy_o;
  logic        err_o;
  // RATIO=1 build
  logic        v1;
  logic [15:0] d1;
  logic        rdy1;
  logic        tok1;
  logic [1:0]  iov1;
  logic [15:0] iod1;
  logic [4:0]  cred1;
  logic [6:0]  sent1;
  logic        busy1;
  logic        err1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  link_upstream_serializer u_dut (
    .clk                  (clk),
    .rst                  (rst),
    .core_valid_i         (core_valid_i),
    .core_data_i          (core_data_i),
    .core_ready_o         (core_ready_o),
    .io_token_i           (io_token_i),
    .io_valid_o           (io_valid_o),
    .io_data_o            (io_data_o),
    .credit_cnt_o         (credit_cnt_o),
    .sent_cnt_o           (sent_cnt_o),
    .busy_o               (busy_o),
    .err_token_overflow_o (err_o)
  );

  link_upstream_serializer #(.RATIO(1)) u_dut_r1 (
    .clk                  (clk),
    .rst                  (rst),
    .core_valid_i         (v1),
    .core_data_i          (d1),
    .core_ready_o         (rdy1),
    .io_token_i           (tok1),
    .io_valid_o           (iov1),
    .io_data_o            (iod1),
    .credit_cnt_o         (cred1),
    .sent_cnt_o           (sent1),
    .busy_o               (busy1),
    .err_token_overflow_o (err1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] beat_of(input int idx);
    return {8'(8'hA0 + idx / 4), 8'(idx % 4)};
  endfunction

  function automatic logic [63:0] word_of(input int j);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = beat_of(j * 4 + k);
    return w;
  endfunction

  task automatic send_word(input logic [63:0] d);
    int n;
    n = 0;
    while (!core_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_eq("ready_timeout", 64'(core_ready_o), 64'd1);
    core_valid_i = 1'b1;
    core_data_i  = d;
    tick();
    core_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_eq("idle_timeout", 64'(busy_o), 64'd0);
  endtask

  task automatic pulse_token();
    io_token_i = 1'b1;
    tick();
    io_token_i = 1'b0;
  endtask

  initial begin
    int j;
    int b;
    int beat_ok;
    logic acc;

    rst = 1'b1;
    core_valid_i = 1'b0;
    core_data_i = '0;
    io_token_i = 1'b0;
    v1 = 1'b0;
    d1 = '0;
    tok1 = 1'b0;

    // reset defaults
    tick();
    tick();
    check_eq("rst_valid", 64'(io_valid_o), 64'h0);
    check_eq("rst_data", 64'(io_data_o), 64'h0);
    check_eq("rst_credit", 64'(credit_cnt_o), 64'd16);
    check_eq("rst_sent", 64'(sent_cnt_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_err", 64'(err_o), 64'd0);
    check_eq("rst_credit_r1", 64'(cred1), 64'd16);
    rst = 1'b0;
    check_eq("rst_ready", 64'(core_ready_o), 64'd1);

    // single word, LSB slice first
    core_valid_i = 1'b1;
    core_data_i  = 64'h8877_6655_4433_2211;
    tick();
    core_valid_i = 1'b0;
    core_data_i  = 64'hFFFF_FFFF_FFFF_FFFF;
    check_eq("w1_b0", {46'd0, io_valid_o, io_data_o}, {46'd0, 2'b11, 16'h2211});
    tick();
    check_eq("w1_b1", {46'd0, io_valid_o, io_data_o}, {46'd0, 2'b11, 16'h4433});
    tick();
    check_eq("w1_b2", {46'd0, io_valid_o, io_data_o}, {46'd0, 2'b11, 16'h6655});
    tick();
    check_eq("w1_b3", {46'd0, io_valid_o, io_data_o}, {46'd0, 2'b11, 16'h8877});
    tick();
    check_eq("w1_done_valid", 64'(io_valid_o), 64'h0);
    check_eq("w1_hold_data", 64'(io_data_o), 64'h8877);
    check_eq("w1_sent", 64'(sent_cnt_o), 64'd1);
    check_eq("w1_credit", 64'(credit_cnt_o), 64'd15);

    // 16 back-to-back words drain all credits
    rst = 1'b1;
    tick();
    rst = 1'b0;
    core_valid_i = 1'b1;
    j = 0;
    b = 0;
    beat_ok = 0;
    core_data_i = word_of(0);
    for (int it = 1; it <= 65; it++) begin
      acc = core_ready_o;
      tick();
      if (acc) begin
        j++;
        core_data_i = word_of(j);
      end
      if (it <= 64 && io_valid_o == 2'b11 && io_data_o == beat_of(b)) beat_ok++;
      if (io_valid_o == 2'b11) b++;
    end
    core_valid_i = 1'b0;
    check_eq("burst_contig_beats", 64'(beat_ok), 64'd64);
    check_eq("burst_total_beats", 64'(b), 64'd64);
    check_eq("burst_accepts", 64'(j), 64'd16);
    check_eq("burst_credit", 64'(credit_cnt_o), 64'd0);
    check_eq("burst_ready", 64'(core_ready_o), 64'd0);
    check_eq("burst_sent", 64'(sent_cnt_o), 64'd16);
    pulse_token();
    check_eq("tok_credit", 64'(credit_cnt_o), 64'd4);
    check_eq("tok_ready", 64'(core_ready_o), 64'd1);

    // credit=1 with accept and token in the same cycle
    send_word(word_of(100));
    send_word(word_of(101));
    send_word(word_of(102));
    wait_idle();
    check_eq("c1_credit", 64'(credit_cnt_o), 64'd1);
    check_eq("c1_sent", 64'(sent_cnt_o), 64'd19);
    core_valid_i = 1'b1;
    io_token_i   = 1'b1;
    core_data_i  = 64'hDEAD_BEEF_CAFE_F00D;
    tick();
    core_valid_i = 1'b0;
    io_token_i   = 1'b0;
    check_eq("c1_net_credit", 64'(credit_cnt_o), 64'd4);
    check_eq("c1_b0", 64'(io_data_o), 64'hF00D);
    tick();
    check_eq("c1_b1", 64'(io_data_o), 64'hCAFE);
    tick();
    check_eq("c1_b2", 64'(io_data_o), 64'hBEEF);
    tick();
    check_eq("c1_b3", {46'd0, io_valid_o, io_data_o}, {46'd0, 2'b11, 16'hDEAD});
    tick();
    check_eq("c1_sent", 64'(sent_cnt_o), 64'd20);

    // overflow: bring credits to 14, then one more token
    send_word(word_of(3));
    send_word(word_of(4));
    wait_idle();
    pulse_token();
    pulse_token();
    pulse_token();
    check_eq("ov_pre_credit", 64'(credit_cnt_o), 64'd14);
    check_eq("ov_pre_err", 64'(err_o), 64'd0);
    pulse_token();
    check_eq("ov_credit", 64'(credit_cnt_o), 64'd16);
    check_eq("ov_err", 64'(err_o), 64'd1);
    send_word(word_of(5));
    wait_idle();
    check_eq("ov_after_credit", 64'(credit_cnt_o), 64'd15);
    check_eq("ov_sticky", 64'(err_o), 64'd1);
    check_eq("ov_sent", 64'(sent_cnt_o), 64'd23);

    // reset during beat 2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rr_err_clear", 64'(err_o), 64'd0);
    core_valid_i = 1'b1;
    core_data_i  = 64'h1111_2222_3333_4444;
    tick();
    core_valid_i = 1'b0;
    tick();
    tick();
    check_eq("rr_beat2", 64'(io_data_o), 64'h2222);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("rr_valid", 64'(io_valid_o), 64'h0);
    check_eq("rr_credit", 64'(credit_cnt_o), 64'd16);
    check_eq("rr_sent", 64'(sent_cnt_o), 64'd0);
    tick();
    check_eq("rr_sent_later", 64'(sent_cnt_o), 64'd0);
    check_eq("rr_valid_later", 64'(io_valid_o), 64'h0);

    // RATIO=1: four back-to-back single-beat words
    v1 = 1'b1;
    d1 = 16'hA001;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("r1_ready%0d", k), 64'(rdy1), 64'd1);
      tick();
      check_eq($sformatf("r1_beat%0d", k), {46'd0, iov1, iod1}, {46'd0, 2'b11, 16'(16'hA001 + k)});
      d1 = 16'(16'hA002 + k);
    end
    v1 = 1'b0;
    check_eq("r1_busy_run", 64'(busy1), 64'd1);
    tick();
    check_eq("r1_idle_valid", 64'(iov1), 64'h0);
    check_eq("r1_idle_busy", 64'(busy1), 64'd0);
    check_eq("r1_sent", 64'(sent1), 64'd4);
    check_eq("r1_credit", 64'(cred1), 64'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
